platform_field: RTL and testbench

Owns the scrolling platform set that the doodle state machine jumps on. It answers the doodle FSM's collision query, "is the doodle's foot on a platform?", through a req/ack handshake. It scrolls platforms down when the doodle is above the screen middle, respawns platforms that leave the bottom, and supplies a per-pixel platform flag to the VGA colour mux.

---
 rtl/platform_field_if.sv | 15 +
 rtl/platform_field.sv | 211 +++++++++++++++++++++
 tb/tb_platform_field.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/platform_field_if.sv
`timescale 1ns/1ps
// Collision query handshake between the doodle FSM (master) and the platform field (slave).
interface platform_field_if;
  logic       query_req;
  logic [9:0] query_x;
  logic [9:0] query_y;
  logic       query_ack;
  logic       query_hit;
  logic [9:0] hit_y;

  modport master (output query_req, query_x, query_y,
                  input  query_ack, query_hit, hit_y);
  modport slave  (input  query_req, query_x, query_y,
                  output query_ack, query_hit, hit_y);
endinterface

// File: rtl/platform_field.sv
`timescale 1ns/1ps
// Scrolling platform set: builds the field, scrolls and respawns platforms,
// answers foot-on-platform queries and flags platform pixels for the VGA mux.
module platform_field #(
  parameter int          NUM_PLAT  = 8,
  parameter int          PLAT_W    = 60,
  parameter int          PLAT_H    = 8,
  parameter int          DOODLE_W  = 40,
  parameter int          SPACING   = 60,
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             frame_tick,
  input  logic             scroll_en,
  input  logic [3:0]       scroll_amt,
  platform_field_if.slave  qry,
  input  logic [9:0]       hCount,
  input  logic [9:0]       vCount,
  output logic             plat_pixel,
  output logic             busy,
  output logic [7:0]       spawn_count
);

  localparam int IW     = $clog2(NUM_PLAT + 1);
  localparam int SW     = $clog2(NUM_PLAT);
  localparam int X_SPAN = H_RES - PLAT_W;

  typedef enum logic [1:0] {IDLE, INIT, RUN, SCAN} state_t;
  state_t state, state_nxt;

  logic [9:0]    px [NUM_PLAT];
  logic [9:0]    py [NUM_PLAT];
  logic [9:0]    px_scr [NUM_PLAT];
  logic [9:0]    py_scr [NUM_PLAT];
  logic [15:0]   lfsr, lfsr_scr;
  logic [7:0]    spawn_inc;
  logic [IW-1:0] idx;
  logic [SW-1:0] slot;
  logic          pending;
  logic [3:0]    pend_amt, amt_eff;
  logic          tick_in, do_scroll;
  logic [9:0]    qx, qy;
  logic          found;
  logic [9:0]    found_y;
  logic          slot_hit;
  logic [9:0]    init_py;
  logic          pix_nxt;

  function automatic logic [9:0] x_from(input logic [9:0] r);
    if (r >= 10'(X_SPAN)) return r - 10'(X_SPAN);
    return r;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = INIT;
      INIT: if (Start) state_nxt = INIT;
            else if (idx == IW'(NUM_PLAT - 1)) state_nxt = RUN;
      RUN:  if (Start) state_nxt = INIT;
            else if (qry.query_req) state_nxt = SCAN;
      SCAN: if (Start) state_nxt = INIT;
            else if (idx == IW'(NUM_PLAT)) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == INIT) || (state == SCAN);
  end

  // Slot geometry for the INIT write and the SCAN overlap test.
  always_comb begin
    int t;
    slot = idx[SW-1:0];
    t = V_RES - 20 - int'(idx) * SPACING;
    if (t < 0) t = t + V_RES;
    init_py = 10'(t);
    slot_hit = ({1'b0, qx} + 11'(DOODLE_W) > {1'b0, px[slot]}) &&
               ({1'b0, qx} < {1'b0, px[slot]} + 11'(PLAT_W)) &&
               ({1'b0, qy} >= {1'b0, py[slot]}) &&
               ({1'b0, qy} < {1'b0, py[slot]} + 11'(PLAT_H));
  end

  // Scrolled positions; respawning slots draw LFSR x values in ascending index order.
  always_comb begin
    logic [10:0] sum;
    tick_in   = frame_tick && scroll_en;
    do_scroll = pending || tick_in;
    amt_eff   = pending ? pend_amt : scroll_amt;
    lfsr_scr  = lfsr;
    spawn_inc = 8'd0;
    for (int k = 0; k < NUM_PLAT; k++) begin
      sum = {1'b0, py[k]} + {7'd0, amt_eff};
      if (sum >= 11'(V_RES)) begin
        py_scr[k] = 10'(sum - 11'(V_RES));
        px_scr[k] = x_from(lfsr_scr[9:0]);
        lfsr_scr  = lfsr_step(lfsr_scr);
        spawn_inc = spawn_inc + 8'd1;
      end else begin
        py_scr[k] = sum[9:0];
        px_scr[k] = px[k];
      end
    end
  end

  always_comb begin
    pix_nxt = 1'b0;
    for (int k = 0; k < NUM_PLAT; k++) begin
      if (({1'b0, hCount} >= {1'b0, px[k]}) && ({1'b0, hCount} < {1'b0, px[k]} + 11'(PLAT_W)) &&
          ({1'b0, vCount} >= {1'b0, py[k]}) && ({1'b0, vCount} < {1'b0, py[k]} + 11'(PLAT_H)))
        pix_nxt = 1'b1;
    end
  end

  // Start discards pending motion; ticks seen while busy are deferred to the first RUN cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NUM_PLAT; k++) begin
        px[k] <= '0;
        py[k] <= '0;
      end
      lfsr          <= LFSR_SEED;
      idx           <= '0;
      pending       <= 1'b0;
      pend_amt      <= '0;
      qx            <= '0;
      qy            <= '0;
      found         <= 1'b0;
      found_y       <= '0;
      qry.query_ack <= 1'b0;
      qry.query_hit <= 1'b0;
      qry.hit_y     <= '0;
      spawn_count   <= '0;
    end else begin
      qry.query_ack <= 1'b0;
      if (Start) begin
        idx         <= '0;
        pending     <= 1'b0;
        spawn_count <= '0;
      end else begin
        case (state)
          INIT: begin
            px[slot] <= x_from(lfsr[9:0]);
            py[slot] <= init_py;
            lfsr     <= lfsr_step(lfsr);
            idx      <= idx + IW'(1);
            if (tick_in && !pending) begin
              pending  <= 1'b1;
              pend_amt <= scroll_amt;
            end
          end
          RUN: begin
            if (do_scroll) begin
              for (int k = 0; k < NUM_PLAT; k++) begin
                px[k] <= px_scr[k];
                py[k] <= py_scr[k];
              end
              lfsr        <= lfsr_scr;
              spawn_count <= spawn_count + spawn_inc;
              pending     <= 1'b0;
            end
            if (qry.query_req) begin
              qx    <= qry.query_x;
              qy    <= qry.query_y;
              idx   <= '0;
              found <= 1'b0;
            end
          end
          SCAN: begin
            if (idx < IW'(NUM_PLAT)) begin
              if (slot_hit && !found) begin
                found   <= 1'b1;
                found_y <= py[slot];
              end
              idx <= idx + IW'(1);
            end else begin
              qry.query_ack <= 1'b1;
              qry.query_hit <= found;
              qry.hit_y     <= found ? found_y : 10'd0;
            end
            if (tick_in && !pending) begin
              pending  <= 1'b1;
              pend_amt <= scroll_amt;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) plat_pixel <= 1'b0;
    else       plat_pixel <= pix_nxt;
  end

endmodule

// File: tb/tb_platform_field.sv
`timescale 1ns/1ps
// Platform field bench: constant vectors, multi-cycle corner sequences and
// randomized traffic compared with an array-based model of the platform set.
module tb_platform_field;

  localparam int NP    = 8;
  localparam int PW    = 60;
  localparam int PH    = 8;
  localparam int DW    = 40;
  localparam int VR    = 480;
  localparam int XSPAN = 580;

  logic       Clk = 1'b0;
  logic       Reset, Start, frame_tick, scroll_en;
  logic [3:0] scroll_amt;
  logic [9:0] hCount, vCount;
  logic       plat_pixel, busy;
  logic [7:0] spawn_count;

  platform_field_if qry();

  platform_field dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .frame_tick(frame_tick),
    .scroll_en(scroll_en), .scroll_amt(scroll_amt), .qry(qry),
    .hCount(hCount), .vCount(vCount), .plat_pixel(plat_pixel),
    .busy(busy), .spawn_count(spawn_count)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int          mpx [NP];
  int          mpy [NP];
  logic [15:0] mlfsr;
  int          mspawn;

  typedef struct {
    bit isQuery;
    int x;
    int y;
    int expHit;
    int expY;
  } vec_t;
  vec_t vecs [14];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  function automatic int clamp10(input int v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  // Platform x positions come from a 16-bit LFSR drawn once per placement.
  function automatic int mNextX();
    int r;
    r = int'(mlfsr[9:0]);
    mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    return (r >= XSPAN) ? r - XSPAN : r;
  endfunction

  function automatic void modelInit();
    for (int i = 0; i < NP; i++) begin
      int v;
      v = VR - 20 - i * 60;
      if (v < 0) v = v + VR;
      mpy[i] = v;
      mpx[i] = mNextX();
    end
    mspawn = 0;
  endfunction

  function automatic void modelScroll(input int amt);
    for (int i = 0; i < NP; i++) begin
      mpy[i] = mpy[i] + amt;
      if (mpy[i] >= VR) begin
        mpy[i] = mpy[i] - VR;
        mpx[i] = mNextX();
        mspawn = (mspawn + 1) % 256;
      end
    end
  endfunction

  function automatic void modelQuery(input int qx, input int qy, output int hit, output int y);
    hit = 0;
    y   = 0;
    for (int i = 0; i < NP; i++) begin
      if (hit == 0 && qx + DW > mpx[i] && qx < mpx[i] + PW && qy >= mpy[i] && qy < mpy[i] + PH) begin
        hit = 1;
        y   = mpy[i];
      end
    end
  endfunction

  function automatic int modelPixel(input int h, input int v);
    for (int i = 0; i < NP; i++)
      if (h >= mpx[i] && h < mpx[i] + PW && v >= mpy[i] && v < mpy[i] + PH) return 1;
    return 0;
  endfunction

  // Issues one query (optionally with a scroll in the same cycle) and waits for its ack.
  task automatic doQuery(input int qx, input int qy, input int scr,
                         output int lat, output int hit, output int y);
    qry.query_req = 1'b1;
    qry.query_x   = 10'(qx);
    qry.query_y   = 10'(qy);
    if (scr >= 0) begin
      frame_tick = 1'b1;
      scroll_en  = 1'b1;
      scroll_amt = 4'(scr);
    end
    tick();
    qry.query_req = 1'b0;
    frame_tick    = 1'b0;
    scroll_en     = 1'b0;
    if (scr >= 0) modelScroll(scr);
    lat = -1;
    hit = 0;
    y   = 0;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      tick();
      if (qry.query_ack) begin
        lat = n;
        hit = int'(qry.query_hit);
        y   = int'(qry.hit_y);
      end
    end
  endtask

  task automatic queryVsModel(input int qx, input int qy, input int scr);
    int lat, hit, y, eh, ey;
    doQuery(qx, qy, scr, lat, hit, y);
    modelQuery(qx, qy, eh, ey);
    checkOutput("query_latency", lat, NP + 1);
    checkOutput("query_hit", hit, eh);
    checkOutput("hit_y", y, ey);
  endtask

  task automatic doScroll(input bit en, input int amt);
    frame_tick = 1'b1;
    scroll_en  = en;
    scroll_amt = 4'(amt);
    tick();
    frame_tick = 1'b0;
    scroll_en  = 1'b0;
    if (en) modelScroll(amt);
    checkOutput("spawn_count", int'(spawn_count), mspawn);
  endtask

  task automatic pixelVsModel(input int h, input int v);
    hCount = 10'(h);
    vCount = 10'(v);
    tick();
    checkOutput("plat_pixel", int'(plat_pixel), modelPixel(h, v));
  endtask

  task automatic doStart(output int acks);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    modelInit();
    acks = int'(qry.query_ack);
    for (int i = 0; i < NP; i++) begin
      checkOutput("busy_init", int'(busy), 1);
      tick();
      if (qry.query_ack) acks++;
    end
    checkOutput("busy_done", int'(busy), 0);
    checkOutput("spawn_init", int'(spawn_count), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat, hit, y;
    if (v.isQuery) begin
      doQuery(v.x, v.y, -1, lat, hit, y);
      checkOutput("vec_latency", lat, NP + 1);
      checkOutput("vec_hit", hit, v.expHit);
      checkOutput("vec_hit_y", y, v.expY);
    end else begin
      hCount = 10'(v.x);
      vCount = 10'(v.y);
      tick();
      checkOutput("vec_pixel", int'(plat_pixel), v.expHit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks, lat, hit, y, eh, ey, prePix, postPix, k;

    Reset = 1'b1; Start = 1'b0; frame_tick = 1'b0; scroll_en = 1'b0; scroll_amt = 4'd0;
    hCount = 10'd700; vCount = 10'd700;
    qry.query_req = 1'b0; qry.query_x = 10'd0; qry.query_y = 10'd0;
    mlfsr = 16'hACE1;
    mspawn = 0;
    for (int i = 0; i < NP; i++) begin mpx[i] = 0; mpy[i] = 0; end

    repeat (3) tick();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_ack", int'(qry.query_ack), 0);
    checkOutput("rst_hit", int'(qry.query_hit), 0);
    checkOutput("rst_hit_y", int'(qry.hit_y), 0);
    checkOutput("rst_spawn", int'(spawn_count), 0);
    checkOutput("rst_pixel", int'(plat_pixel), 0);
    Reset = 1'b0;
    repeat (2) tick();

    // A query while idle must never be acknowledged.
    qry.query_req = 1'b1;
    tick();
    qry.query_req = 1'b0;
    acks = 0;
    repeat (12) begin tick(); if (qry.query_ack) acks++; end
    checkOutput("idle_query_ack", acks, 0);

    doStart(acks);

    vecs[0]  = '{1'b1, 200, 462, 1, 460};
    vecs[1]  = '{1'b1,   0, 300, 0,   0};
    vecs[2]  = '{1'b1, 185, 460, 0,   0};
    vecs[3]  = '{1'b1, 186, 460, 1, 460};
    vecs[4]  = '{1'b1, 284, 467, 1, 460};
    vecs[5]  = '{1'b1, 285, 464, 0,   0};
    vecs[6]  = '{1'b1, 230, 468, 0,   0};
    vecs[7]  = '{1'b1, 230, 459, 0,   0};
    vecs[8]  = '{1'b0, 225, 460, 1,   0};
    vecs[9]  = '{1'b0, 284, 467, 1,   0};
    vecs[10] = '{1'b0, 285, 460, 0,   0};
    vecs[11] = '{1'b0, 224, 463, 0,   0};
    vecs[12] = '{1'b0, 250, 468, 0,   0};
    vecs[13] = '{1'b0, 250, 459, 0,   0};
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    doQuery(mpx[7] + 20, 40, -1, lat, hit, y);
    checkOutput("slot7_hit", hit, 1);
    checkOutput("slot7_y", y, 40);

    // Two 10-pixel scrolls push slot 0 from 460 to 480, which wraps it to the top.
    doScroll(1'b1, 10);
    doScroll(1'b1, 10);
    checkOutput("spawn_after_wrap", int'(spawn_count), 1);
    hCount = 10'(mpx[1] + 1); vCount = 10'd420; tick();
    checkOutput("slot1_moved_in", int'(plat_pixel), 1);
    hCount = 10'(mpx[1] + 1); vCount = 10'd419; tick();
    checkOutput("slot1_moved_out", int'(plat_pixel), 0);
    doQuery(mpx[0] + 5, 3, -1, lat, hit, y);
    checkOutput("slot0_wrap_hit", hit, 1);
    checkOutput("slot0_wrap_y", y, 0);

    // Ticks during SCAN: first deferred to just after the ack, second dropped; a req while busy is ignored.
    hCount = 10'(mpx[1]); vCount = 10'(mpy[1]);
    prePix = modelPixel(mpx[1], mpy[1]);
    modelQuery(mpx[2] + 3, mpy[2] + 1, eh, ey);
    qry.query_req = 1'b1; qry.query_x = 10'(mpx[2] + 3); qry.query_y = 10'(mpy[2] + 1);
    tick();
    qry.query_req = 1'b0;
    modelScroll(5);
    postPix = modelPixel(mpx[1] - 0, mpy[1] - 5);
    postPix = modelPixel(int'(hCount), int'(vCount));
    acks = 0; lat = -1; hit = 0; y = 0;
    for (int n = 1; n <= 25; n++) begin
      frame_tick    = (n == 3 || n == 5);
      scroll_en     = (n == 3 || n == 5);
      scroll_amt    = (n == 3) ? 4'd5 : 4'd9;
      qry.query_req = (n == 4);
      tick();
      frame_tick = 1'b0; scroll_en = 1'b0; qry.query_req = 1'b0;
      if (qry.query_ack) begin
        acks++;
        if (lat < 0) begin lat = n; hit = int'(qry.query_hit); y = int'(qry.hit_y); end
      end
      if (lat > 0 && n == lat + 1) checkOutput("pix_before_deferred_scroll", int'(plat_pixel), prePix);
      if (lat > 0 && n == lat + 2) checkOutput("pix_after_deferred_scroll", int'(plat_pixel), postPix);
    end
    checkOutput("scan_tick_latency", lat, NP + 1);
    checkOutput("scan_ack_count", acks, 1);
    checkOutput("scan_tick_hit", hit, eh);
    checkOutput("scan_tick_hit_y", y, ey);
    checkOutput("scan_tick_spawn", int'(spawn_count), mspawn);
    queryVsModel(mpx[3] + 10, mpy[3] + 2, -1);

    // Start during SCAN aborts the query; the LFSR carries on from where it was.
    qry.query_req = 1'b1; qry.query_x = 10'(mpx[0] + 5); qry.query_y = 10'(mpy[0] + 1);
    tick();
    qry.query_req = 1'b0;
    acks = 0;
    repeat (3) begin tick(); if (qry.query_ack) acks++; end
    begin
      int a2;
      doStart(a2);
      acks += a2;
    end
    repeat (12) begin tick(); if (qry.query_ack) acks++; end
    checkOutput("abort_no_ack", acks, 0);
    queryVsModel(mpx[0] + 5, mpy[0] + 1, -1);
    queryVsModel(mpx[4] + 1, mpy[4] + 7, -1);

    for (int it = 0; it < 250; it++) begin
      k = int'($urandom_range(0, NP - 1));
      case ($urandom_range(0, 3))
        0: doScroll(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        1: queryVsModel(clamp10(mpx[k] + int'($urandom_range(0, 100)) - 40),
                        clamp10(mpy[k] + int'($urandom_range(0, 10)) - 1), -1);
        2: queryVsModel(clamp10(mpx[k] + int'($urandom_range(0, 100)) - 40),
                        clamp10(mpy[k] + int'($urandom_range(0, 24)) - 1),
                        int'($urandom_range(0, 15)));
        default: pixelVsModel(clamp10(mpx[k] + int'($urandom_range(0, 64)) - 2),
                              clamp10(mpy[k] + int'($urandom_range(0, 11)) - 2));
      endcase
    end

    // Enough full-speed scrolling to carry spawn_count past 255.
    for (int it = 0; it < 1100; it++) doScroll(1'b1, 15);
    queryVsModel(mpx[5] + 2, mpy[5] + 3, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
